rtype_encoder: RTL and testbench
================================

# rtype_encoder

Encodes ALU operation requests into 32-bit RV32I R-type instruction words and writes them into consecutive words of instruction memory. It is the encoder for the core's R-type decoder and uses the same 3-bit aluop codes. The program generator sits on the request side; the instruction memory write port sits on the output side. A run ends with a NOP terminator.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begins a run from IDLE or DONE
- finish  in  1  pulse; closes a run in RUN
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_aluop  in  3  0 add, 1 sub, 4 and, 5 or, 7 xor; 2/3/6 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- imem_we  out  1  memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this run, terminator included
- done  out  1  high in DONE
- err  out  1  sticky; an illegal aluop was accepted this run

## Operation
- States: IDLE, RUN, TERM, DONE. All outputs reset to 0; state resets to IDLE.
- IDLE/DONE + start -> RUN, with count=0, write pointer=0 and err=0. In RUN and TERM, start is ignored.
- RUN + finish -> TERM. TERM -> DONE unconditionally after one cycle.
- in_ready = (state==RUN) && (pointer < DEPTH-1). The last word is always reserved for the terminator.
- Encoding: word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct7 = 7'b0100000 for sub, 0 otherwise.
  - funct3: add/sub 000, and 111, or 110, xor 100.
- Legal accepted request: registered write of the word at the pointer; then pointer+1 and count+1.
- Illegal aluop: the request is still accepted (handshake completes). Nothing is written, the pointer is unchanged, and err is set.
- TERM: writes NOP 0x00000013 at the pointer; count+1.
- finish together with an accepted request: the request is written first, then the NOP at the next address.
- finish in IDLE or DONE: ignored. finish while full: the terminator still goes into the reserved last word.
- No wrap-around. A run is at most DEPTH words.

## Timing
- Request accepted on edge N -> imem_we=1 with addr/wdata during cycle N+1. count updates on the same edge as the write.
- finish sampled on edge N -> TERM during cycle N+1 -> NOP imem_we during cycle N+2 -> done=1 from cycle N+2.
- imem_we is high for exactly one cycle per word. When imem_we=0, imem_addr/imem_wdata hold their last values.
- Throughput is one request per cycle while in_ready=1.
- in_ready is combinational from state and pointer only. It has no dependence on in_valid.
- rst at any time: immediate return to IDLE with all outputs at 0. An in-flight write is dropped (imem_we falls asynchronously).

## Structure
- Shared package holds:
  - aluop codes (ALU_ADD=0, ALU_SUB=1, ALU_AND=4, ALU_OR=5, ALU_XOR=7), shared with the decoder
  - OPC_RTYPE=7'b0110011, the funct3/funct7 constants, NOP_WORD=32'h00000013
  - the state enum
- One natural sub-module: rtype_word_enc, a pure combinational fields-to-word function with a legal flag. Everything else is the control FSM and output register in the top module.

## Test plan
- start; add rd=3,rs1=1,rs2=2; sub same regs; finish -> writes 0x002081B3@0, 0x402081B3@1, 0x00000013@2; count=3; done=1; err=0.
- xor rd=5,rs1=6,rs2=7, finish in the same cycle -> 0x007342B3@0 in cycle N+1, NOP@1 in cycle N+2.
- aluop=2 between two adds -> only the two adds are written, at addresses 0 and 1; err=1. A new start clears err and count.
- ADDR_W=2: three requests fill words 0-2 and in_ready drops; finish writes NOP@3; count=4.
- 10 back-to-back requests with in_valid held -> one write per cycle at addresses 0..9, no gaps.
- rst asserted mid-run with imem_we=1 -> imem_we/count/done fall immediately; after release, start begins again at address 0.

Source files
------------

// File: rtl/rtype_encoder_pkg.sv
// Shared definitions for the R-type encoder and the core's R-type decoder:
// aluop codes, instruction field constants and the encoder control states.
package rtype_encoder_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_XOR     = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TERM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rtype_word_enc.sv
// Pure combinational packing of aluop and register fields into an RV32I
// R-type word, with a flag telling whether the aluop has an encoding.
module rtype_word_enc
    import rtype_encoder_pkg::*;
(
    input  logic [2:0]  aluop_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    // Map the aluop onto funct3/funct7; codes 2, 3 and 6 have no encoding.
    always_comb begin
        funct3  = F3_ADD_SUB;
        funct7  = F7_BASE;
        legal_o = 1'b1;
        case (aluop_i)
            ALU_ADD: funct3 = F3_ADD_SUB;
            ALU_SUB: begin
                funct3 = F3_ADD_SUB;
                funct7 = F7_SUB;
            end
            ALU_AND: funct3 = F3_AND;
            ALU_OR:  funct3 = F3_OR;
            ALU_XOR: funct3 = F3_XOR;
            default: legal_o = 1'b0;
        endcase
    end

    assign word_o = {funct7, rs2_i, rs1_i, funct3, rd_i, OPC_RTYPE};

endmodule

// File: rtl/rtype_encoder.sv
// Accepts ALU operation requests, encodes them as R-type words and writes
// them to consecutive instruction-memory words, closing each run with a NOP.
module rtype_encoder
    import rtype_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_aluop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    // The last word is never handed to a request: it stays free for the NOP.
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                done_q;
    logic                err_q;

    logic [31:0]         encWord;
    logic                encLegal;
    logic                accept;

    rtype_word_enc u_word_enc (
        .aluop_i (in_aluop),
        .rd_i    (in_rd),
        .rs1_i   (in_rs1),
        .rs2_i   (in_rs2),
        .word_o  (encWord),
        .legal_o (encLegal)
    );

    assign in_ready = (state_q == ST_RUN) && (ptr_q != LAST_ADDR);
    assign accept   = in_valid && in_ready;
    assign ptr_d    = ptr_q + 1'b1;
    assign count_d  = count_q + 1'b1;

    // Control FSM and registered write port; writes last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        ptr_q   <= '0;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (encLegal) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q;
                            wdata_q <= encWord;
                            ptr_q   <= ptr_d;
                            count_q <= count_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (finish) begin
                        state_q <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    we_q    <= 1'b1;
                    addr_q  <= ptr_q;
                    wdata_q <= NOP_WORD;
                    count_q <= count_d;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rtype_encoder.sv
// Self-checking bench for rtype_encoder: a default-depth instance and a
// four-word instance share all inputs, and each has its own write log.
module tb_rtype_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        finish;
    logic        in_valid;
    logic [2:0]  in_aluop;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;

    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;
    logic        done;
    logic        err;

    logic        s_ready;
    logic        s_we;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;
    logic        s_done;
    logic        s_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t logBig[$];
    wr_t logSmall[$];

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] expWord;
        logic        expLegal;
    } vec_t;

    typedef struct {
        bit v;
        int op;
        int rd;
        int rs1;
        int rs2;
    } req_t;

    req_t reqs[$];

    rtype_encoder #(.ADDR_W(8)) dutBig (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err(err)
    );

    rtype_encoder #(.ADDR_W(2)) dutSmall (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(s_ready), .in_aluop(in_aluop),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .count(s_count), .done(s_done), .err(s_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Record every memory write of both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) logBig.push_back('{addr: 32'(imem_addr), data: imem_wdata});
        if (s_we) logSmall.push_back('{addr: 32'(s_addr), data: s_wdata});
    end

    // Hard time limit so the run always terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference encoding built from the instruction field layout.
    function automatic logic [31:0] refEncode(input int op, input int rd, input int rs1, input int rs2);
        int f3;
        int f7;
        f7 = (op == 1) ? 32 : 0;
        case (op)
            4:       f3 = 7;
            5:       f3 = 6;
            7:       f3 = 4;
            default: f3 = 0;
        endcase
        return 32'(f7 * (2 ** 25) + rs2 * (2 ** 20) + rs1 * (2 ** 15) + f3 * (2 ** 12) + rd * (2 ** 7) + 51);
    endfunction

    function automatic bit refLegal(input int op);
        return (op == 0) || (op == 1) || (op == 4) || (op == 5) || (op == 7);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, let the DUT sample them, then drop the pulses.
    task automatic applyStimulus(input logic s, input logic f, input logic v, input logic [2:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        start    = s;
        finish   = f;
        in_valid = v;
        in_aluop = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        stepCycle();
        start    = 1'b0;
        finish   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic startRun();
        logBig.delete();
        logSmall.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic checkLogEntry(input string name, input wr_t lg[$], input int idx,
                                 input logic [31:0] expAddr, input logic [31:0] expData);
        if (idx >= lg.size()) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: entry %0d missing, log holds %0d writes", name, idx, lg.size());
        end else begin
            checkOutput({name, " addr"}, lg[idx].addr, expAddr);
            checkOutput({name, " data"}, lg[idx].data, expData);
        end
    endtask

    // Compare one instance's run against the request-list model for its depth.
    task automatic checkRun(input string tag, input int depth, input wr_t lg[$],
                            input int actCount, input logic actErr, input logic actDone);
        int          ptr;
        bit          e;
        logic [31:0] exp[$];
        ptr = 0;
        e   = 1'b0;
        foreach (reqs[i]) begin
            if (reqs[i].v && ptr < depth - 1) begin
                if (refLegal(reqs[i].op)) begin
                    exp.push_back(refEncode(reqs[i].op, reqs[i].rd, reqs[i].rs1, reqs[i].rs2));
                    ptr++;
                end else begin
                    e = 1'b1;
                end
            end
        end
        exp.push_back(32'h00000013);
        checkOutput({tag, " count"}, 32'(actCount), 32'(exp.size()));
        checkOutput({tag, " err"}, 32'(actErr), 32'(e));
        checkOutput({tag, " done"}, 32'(actDone), 32'd1);
        checkOutput({tag, " writes"}, 32'(lg.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            checkLogEntry($sformatf("%s word%0d", tag, i), lg, i, 32'(i), exp[i]);
        end
    endtask

    initial begin
        vec_t vecs[9];
        vecs[0] = '{op: 3'd0, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  expWord: 32'h002081B3, expLegal: 1'b1};
        vecs[1] = '{op: 3'd1, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  expWord: 32'h402081B3, expLegal: 1'b1};
        vecs[2] = '{op: 3'd7, rd: 5'd5,  rs1: 5'd6,  rs2: 5'd7,  expWord: 32'h007342B3, expLegal: 1'b1};
        vecs[3] = '{op: 3'd4, rd: 5'd31, rs1: 5'd31, rs2: 5'd31, expWord: 32'h01FFFFB3, expLegal: 1'b1};
        vecs[4] = '{op: 3'd5, rd: 5'd1,  rs1: 5'd0,  rs2: 5'd0,  expWord: 32'h000060B3, expLegal: 1'b1};
        vecs[5] = '{op: 3'd1, rd: 5'd0,  rs1: 5'd31, rs2: 5'd31, expWord: 32'h41FF8033, expLegal: 1'b1};
        vecs[6] = '{op: 3'd2, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  expWord: 32'h00000013, expLegal: 1'b0};
        vecs[7] = '{op: 3'd3, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  expWord: 32'h00000013, expLegal: 1'b0};
        vecs[8] = '{op: 3'd6, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  expWord: 32'h00000013, expLegal: 1'b0};

        rst = 1'b1;
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_aluop = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        repeat (2) stepCycle();

        // Reset state.
        checkOutput("reset we", 32'(imem_we), 32'd0);
        checkOutput("reset addr", 32'(imem_addr), 32'd0);
        checkOutput("reset wdata", imem_wdata, 32'd0);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        stepCycle();
        checkOutput("idle ready", 32'(in_ready), 32'd0);

        // add then sub then finish.
        startRun();
        checkOutput("run ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 5'd3, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 5'd3, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) stepCycle();
        checkLogEntry("addsub w0", logBig, 0, 32'd0, 32'h002081B3);
        checkLogEntry("addsub w1", logBig, 1, 32'd1, 32'h402081B3);
        checkLogEntry("addsub w2", logBig, 2, 32'd2, 32'h00000013);
        checkOutput("addsub writes", 32'(logBig.size()), 32'd3);
        checkOutput("addsub count", 32'(count), 32'd3);
        checkOutput("addsub done", 32'(done), 32'd1);
        checkOutput("addsub err", 32'(err), 32'd0);

        // xor with finish in the same cycle, checked cycle by cycle.
        startRun();
        start = 1'b0; finish = 1'b1; in_valid = 1'b1;
        in_aluop = 3'd7; in_rd = 5'd5; in_rs1 = 5'd6; in_rs2 = 5'd7;
        stepCycle();
        finish = 1'b0; in_valid = 1'b0;
        checkOutput("xorfin c1 we", 32'(imem_we), 32'd1);
        checkOutput("xorfin c1 addr", 32'(imem_addr), 32'd0);
        checkOutput("xorfin c1 data", imem_wdata, 32'h007342B3);
        checkOutput("xorfin c1 done", 32'(done), 32'd0);
        checkOutput("xorfin c1 ready", 32'(in_ready), 32'd0);
        stepCycle();
        checkOutput("xorfin c2 we", 32'(imem_we), 32'd1);
        checkOutput("xorfin c2 addr", 32'(imem_addr), 32'd1);
        checkOutput("xorfin c2 data", imem_wdata, 32'h00000013);
        checkOutput("xorfin c2 done", 32'(done), 32'd1);
        checkOutput("xorfin c2 count", 32'(count), 32'd2);
        stepCycle();
        checkOutput("xorfin c3 we", 32'(imem_we), 32'd0);
        checkOutput("xorfin c3 hold addr", 32'(imem_addr), 32'd1);
        checkOutput("xorfin c3 hold data", imem_wdata, 32'h00000013);

        // Illegal aluop between two adds, then a new start clears err/count.
        startRun();
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 5'd3, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 5'd9, 5'd9, 5'd9);
        checkOutput("illegal ready", 32'(in_ready), 32'd1);
        checkOutput("illegal no write", 32'(imem_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 5'd4, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) stepCycle();
        checkLogEntry("illegal w0", logBig, 0, 32'd0, 32'h002081B3);
        checkLogEntry("illegal w1", logBig, 1, 32'd1, 32'h00208233);
        checkLogEntry("illegal w2", logBig, 2, 32'd2, 32'h00000013);
        checkOutput("illegal writes", 32'(logBig.size()), 32'd3);
        checkOutput("illegal err", 32'(err), 32'd1);
        checkOutput("illegal count", 32'(count), 32'd3);
        startRun();
        checkOutput("restart err", 32'(err), 32'd0);
        checkOutput("restart count", 32'(count), 32'd0);
        checkOutput("restart done", 32'(done), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) stepCycle();

        // Fill the four-word instance; its last word takes the terminator.
        startRun();
        checkOutput("small ready start", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 5'(i + 1), 5'd1, 5'd2);
        end
        checkOutput("small ready full", 32'(s_ready), 32'd0);
        checkOutput("big ready not full", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 5'd8, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkLogEntry($sformatf("small w%0d", i), logSmall, i, 32'(i), refEncode(0, i + 1, 1, 2));
        end
        checkLogEntry("small nop", logSmall, 3, 32'd3, 32'h00000013);
        checkOutput("small writes", 32'(logSmall.size()), 32'd4);
        checkOutput("small count", 32'(s_count), 32'd4);
        checkOutput("small done", 32'(s_done), 32'd1);
        checkOutput("big count alongside", 32'(count), 32'd5);

        // Ten back-to-back requests with in_valid held high.
        startRun();
        in_valid = 1'b1; in_aluop = 3'd5; in_rd = 5'd2; in_rs1 = 5'd3; in_rs2 = 5'd4;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput($sformatf("b2b%0d we", i), 32'(imem_we), 32'd1);
            checkOutput($sformatf("b2b%0d addr", i), 32'(imem_addr), 32'(i));
        end
        in_valid = 1'b0;
        stepCycle();
        checkOutput("b2b gap we", 32'(imem_we), 32'd0);
        checkOutput("b2b count", 32'(count), 32'd10);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) stepCycle();

        // Reset in the middle of a write.
        startRun();
        in_valid = 1'b1; in_aluop = 3'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
        stepCycle();
        checkOutput("rstmid we before", 32'(imem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid we", 32'(imem_we), 32'd0);
        checkOutput("rstmid count", 32'(count), 32'd0);
        checkOutput("rstmid done", 32'(done), 32'd0);
        checkOutput("rstmid ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        stepCycle();
        rst = 1'b0;
        startRun();
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 5'd9, 5'd10, 5'd11);
        checkOutput("rstmid restart addr", 32'(imem_addr), 32'd0);
        checkOutput("rstmid restart data", imem_wdata, refEncode(4, 9, 10, 11));
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) stepCycle();

        // Table of single-request runs.
        foreach (vecs[k]) begin
            startRun();
            applyStimulus(1'b0, 1'b1, 1'b1, vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2);
            repeat (2) stepCycle();
            checkOutput($sformatf("vec%0d err", k), 32'(err), 32'(!vecs[k].expLegal));
            checkOutput($sformatf("vec%0d writes", k), 32'(logBig.size()), vecs[k].expLegal ? 32'd2 : 32'd1);
            checkLogEntry($sformatf("vec%0d w0", k), logBig, 0, 32'd0, vecs[k].expWord);
        end

        // Randomized runs checked against the request-list model on both depths.
        for (int r = 0; r < 8; r++) begin
            int  n;
            bit  finAlone;
            reqs.delete();
            n        = $urandom_range(1, 40);
            finAlone = 1'($urandom_range(0, 1));
            startRun();
            for (int i = 0; i < n; i++) begin
                req_t q;
                q.v   = ($urandom_range(0, 3) != 0);
                q.op  = $urandom_range(0, 7);
                q.rd  = $urandom_range(0, 31);
                q.rs1 = $urandom_range(0, 31);
                q.rs2 = $urandom_range(0, 31);
                reqs.push_back(q);
                applyStimulus(1'b0, (i == n - 1) && !finAlone, 1'(q.v), 3'(q.op),
                              5'(q.rd), 5'(q.rs1), 5'(q.rs2));
            end
            if (finAlone) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
            repeat (2) stepCycle();
            checkRun($sformatf("rand%0d big", r), 256, logBig, int'(count), err, done);
            checkRun($sformatf("rand%0d small", r), 4, logSmall, int'(s_count), s_err, s_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
